// File: rtl/spad_types_pkg.sv
// -----------------------------------------------------------------------------
// spad_types_pkg
// Shared types for the scratchpad SRAM responder slice.
//   NUM_BANKS        : number of SRAM banks addressed by a slot mask
//   SCPAD_ADDR_WIDTH : row address width
//   scpad_data       : one scratchpad data word
//   slot_mask        : one enable bit per bank
//   arb_owner_e      : which requester owns the current operation
//   arb_state_e      : responder FSM state
// -----------------------------------------------------------------------------
package spad_types_pkg;

    localparam int NUM_BANKS        = 4;
    localparam int SCPAD_ADDR_WIDTH = 8;
    localparam int SCPAD_DATA_WIDTH = 32;

    typedef logic [SCPAD_DATA_WIDTH-1:0] scpad_data;
    typedef logic [NUM_BANKS-1:0]        slot_mask;
    typedef logic [SCPAD_ADDR_WIDTH-1:0] scpad_row;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_BE   = 2'd1,
        OWN_VC   = 2'd2,
        OWN_SA   = 2'd3
    } arb_owner_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_e;

    // Only the BE requester writes; VC and SA are read clients.
    function automatic logic owner_is_write(input arb_owner_e owner);
        return owner == OWN_BE;
    endfunction

endpackage

// File: rtl/scpad_prio_arbiter.sv
// -----------------------------------------------------------------------------
// scpad_prio_arbiter
// Combinational fixed-priority grant BE > VC > SA for the SRAM responder.
// Optional feature macro: SCPAD_SA_AGING_EN
//   When defined, a starvation counter tracks IDLE cycles in which SA is
//   requesting but not granted; once it reaches AGE_LIMIT, SA is promoted
//   above VC (BE still wins). The counter clears on an SA grant or whenever
//   SA drops its request. Without the macro there is no state at all.
// Ports:
//   clk, rst        : clock / sync active-high reset (aging build only)
//   arb_en          : arbitration window (responder IDLE and not in reset)
//   req_be/vc/sa    : request lines
//   grant           : winning owner, OWN_NONE when nothing is granted
// -----------------------------------------------------------------------------
module scpad_prio_arbiter
    import spad_types_pkg::*;
`ifdef SCPAD_SA_AGING_EN
#(
    parameter int AGE_LIMIT = 8
)
`endif
(
`ifdef SCPAD_SA_AGING_EN
    input  logic       clk,
    input  logic       rst,
`endif
    input  logic       arb_en,
    input  logic       req_be,
    input  logic       req_vc,
    input  logic       req_sa,
    output arb_owner_e grant
);

`ifdef SCPAD_SA_AGING_EN
    localparam int AGE_W = (AGE_LIMIT < 1) ? 1 : $clog2(AGE_LIMIT + 1);
    localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(AGE_LIMIT);

    logic [AGE_W-1:0] age_q;
    logic             age_hit;

    // Saturate so a long-held SA request cannot wrap back below the limit.
    function automatic logic [AGE_W-1:0] age_sat_inc(input logic [AGE_W-1:0] v);
        return (v >= AGE_MAX) ? AGE_MAX : v + AGE_W'(1);
    endfunction

    assign age_hit = (age_q >= AGE_MAX);

    always_ff @(posedge clk) begin
        if (rst || !req_sa) begin
            age_q <= '0;
        end else if (arb_en) begin
            if (grant == OWN_SA) begin
                age_q <= '0;
            end else begin
                age_q <= age_sat_inc(age_q);
            end
        end
    end
`endif

    always_comb begin
        grant = OWN_NONE;
        if (arb_en) begin
            if (req_be) begin
                grant = OWN_BE;
            end
`ifdef SCPAD_SA_AGING_EN
            else if (age_hit && req_sa) begin
                grant = OWN_SA;
            end
`endif
            else if (req_vc) begin
                grant = OWN_VC;
            end else if (req_sa) begin
                grant = OWN_SA;
            end
        end
    end

endmodule

// File: rtl/scpad_sram_responder.sv
// -----------------------------------------------------------------------------
// scpad_sram_responder
// Single-port SRAM bank responder shared by three requesters: BE (write),
// VC (read) and SA (read). One operation at a time:
//   IDLE  -> arbitrate, pulse sram_reserved_*, latch slot/row/owner/data
//   ISSUE -> drive the bank port for one cycle (write ends here)
//   WAIT  -> count SRAM_LAT cycles, capture bank_rdata on the last one
//   RESP  -> present captured data to the owning read requester
// Latency: grant T, bank access T+1, read response T+2+SRAM_LAT,
//          write back in IDLE at T+2.
// Optional feature macro: SCPAD_SA_AGING_EN (SA starvation promotion,
//   threshold AGE_LIMIT); without it the arbiter is strict priority.
// Parameters:
//   SRAM_LAT  : bank read latency, 1..7
//   AGE_LIMIT : SA aging threshold (aging build only)
// Ports:
//   clk, rst                                 : clock, sync active-high reset
//   sram_req_be/vc/sa                        : requests (held until reserved)
//   be/vc/sa_slot, be/vc/sa_row              : bank mask and row per requester
//   xbar_out                                 : BE write data
//   sram_reserved_be/vc/sa                   : one-cycle grant pulses
//   xbar_in_vc, xbar_in_sa                   : read data to the crossbar
//   resp_valid[1]=VC, [0]=SA, resp_rdata     : read response
//   resp_ready                               : high only in IDLE
//   bank_en/we/row/wdata, bank_rdata         : SRAM bank port
// -----------------------------------------------------------------------------
module scpad_sram_responder
    import spad_types_pkg::*;
#(
    parameter int SRAM_LAT  = 2,
    parameter int AGE_LIMIT = 8
) (
    input  logic                        clk,
    input  logic                        rst,

    input  logic                        sram_req_be,
    input  logic                        sram_req_vc,
    input  logic                        sram_req_sa,
    input  slot_mask                    be_slot,
    input  slot_mask                    vc_slot,
    input  slot_mask                    sa_slot,
    input  logic [SCPAD_ADDR_WIDTH-1:0] be_row,
    input  logic [SCPAD_ADDR_WIDTH-1:0] vc_row,
    input  logic [SCPAD_ADDR_WIDTH-1:0] sa_row,
    input  scpad_data                   xbar_out,

    output logic                        sram_reserved_be,
    output logic                        sram_reserved_vc,
    output logic                        sram_reserved_sa,
    output scpad_data                   xbar_in_vc,
    output scpad_data                   xbar_in_sa,
    output logic [1:0]                  resp_valid,
    output logic                        resp_ready,
    output scpad_data                   resp_rdata,

    output logic [NUM_BANKS-1:0]        bank_en,
    output logic                        bank_we,
    output logic [SCPAD_ADDR_WIDTH-1:0] bank_row,
    output scpad_data                   bank_wdata,
    input  scpad_data                   bank_rdata
);

    if (SRAM_LAT < 1 || SRAM_LAT > 7) begin : g_lat_check
        $error("scpad_sram_responder: SRAM_LAT must be in 1..7");
    end
    if (AGE_LIMIT < 1) begin : g_age_check
        $error("scpad_sram_responder: AGE_LIMIT must be at least 1");
    end

    localparam logic [2:0] LAT_LAST = 3'(SRAM_LAT);

    arb_state_e                  state_q;
    arb_owner_e                  owner_q;
    slot_mask                    slot_q;
    logic [SCPAD_ADDR_WIDTH-1:0] row_q;
    scpad_data                   wdata_q;
    scpad_data                   rdata_q;
    logic [2:0]                  lat_cnt_q;

    arb_owner_e                  grant;
    logic                        arb_en;

    // Reset gates arbitration so no grant pulse can escape while rst is high.
    assign arb_en = (state_q == IDLE) && !rst;

    scpad_prio_arbiter
`ifdef SCPAD_SA_AGING_EN
    #(
        .AGE_LIMIT (AGE_LIMIT)
    )
`endif
    u_arb (
`ifdef SCPAD_SA_AGING_EN
        .clk    (clk),
        .rst    (rst),
`endif
        .arb_en (arb_en),
        .req_be (sram_req_be),
        .req_vc (sram_req_vc),
        .req_sa (sram_req_sa),
        .grant  (grant)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            owner_q   <= OWN_NONE;
            slot_q    <= '0;
            row_q     <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            lat_cnt_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant != OWN_NONE) begin
                        owner_q <= grant;
                        state_q <= ISSUE;
                        case (grant)
                            OWN_BE: begin
                                slot_q  <= be_slot;
                                row_q   <= be_row;
                                wdata_q <= xbar_out;
                            end
                            OWN_VC: begin
                                slot_q  <= vc_slot;
                                row_q   <= vc_row;
                                wdata_q <= '0;
                            end
                            OWN_SA: begin
                                slot_q  <= sa_slot;
                                row_q   <= sa_row;
                                wdata_q <= '0;
                            end
                            default: ;
                        endcase
                    end
                end
                ISSUE: begin
                    if (owner_is_write(owner_q)) begin
                        state_q <= IDLE;
                    end else begin
                        state_q   <= WAIT;
                        lat_cnt_q <= 3'd1;
                    end
                end
                WAIT: begin
                    // Bank data is valid SRAM_LAT cycles after the ISSUE cycle,
                    // which is the last WAIT cycle.
                    if (lat_cnt_q == LAT_LAST) begin
                        rdata_q <= bank_rdata;
                        state_q <= RESP;
                    end else begin
                        lat_cnt_q <= lat_cnt_q + 3'd1;
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        sram_reserved_be = 1'b0;
        sram_reserved_vc = 1'b0;
        sram_reserved_sa = 1'b0;
        xbar_in_vc       = '0;
        xbar_in_sa       = '0;
        resp_valid       = 2'b00;
        resp_ready       = 1'b0;
        resp_rdata       = '0;
        bank_en          = '0;
        bank_we          = 1'b0;
        bank_row         = '0;
        bank_wdata       = '0;
        case (state_q)
            IDLE: begin
                resp_ready       = 1'b1;
                sram_reserved_be = (grant == OWN_BE);
                sram_reserved_vc = (grant == OWN_VC);
                sram_reserved_sa = (grant == OWN_SA);
            end
            ISSUE: begin
                bank_en  = slot_q;
                bank_row = row_q;
                bank_we  = owner_is_write(owner_q);
                if (owner_is_write(owner_q)) begin
                    bank_wdata = wdata_q;
                end
            end
            RESP: begin
                resp_valid = {owner_q == OWN_VC, owner_q == OWN_SA};
                resp_rdata = rdata_q;
                if (owner_q == OWN_VC) begin
                    xbar_in_vc = rdata_q;
                end
                if (owner_q == OWN_SA) begin
                    xbar_in_sa = rdata_q;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: doc/scpad_sram_responder.md
SCPAD_SRAM_RESPONDER -- requirements
Module: scpad_sram_responder

Interface
REQ-001 SHALL have parameter SRAM_LAT, default 2: bank read latency in cycles, legal values 1..7.
REQ-002 SHALL have parameter AGE_LIMIT, default 8: SA starvation threshold, used only with SCPAD_SA_AGING_EN.
REQ-003 SHALL have port clk, input, 1 bit: the single clock.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-005 SHALL have ports sram_req_be, sram_req_vc, sram_req_sa, inputs, 1 bit each: access intent (BE = write; VC and SA = read).
REQ-006 SHALL have ports be_slot, vc_slot, sa_slot, inputs, slot_mask width: bank enable mask per requester.
REQ-007 SHALL have ports be_row, vc_row, sa_row, inputs, SCPAD_ADDR_WIDTH: row address per requester.
REQ-008 SHALL have port xbar_out, input, scpad_data: write data from the crossbar for BE.
REQ-009 SHALL have ports sram_reserved_be, sram_reserved_vc, sram_reserved_sa, outputs, 1 bit each: one-cycle grant pulse.
REQ-010 SHALL have ports xbar_in_vc, xbar_in_sa, outputs, scpad_data: read data toward the crossbar.
REQ-011 SHALL have port resp_valid, output, 2 bits: [1]=VC, [0]=SA.
REQ-012 SHALL have port resp_ready, output, 1 bit: high when idle.
REQ-013 SHALL have port resp_rdata, output, scpad_data.
REQ-014 SHALL have ports bank_en (output, NUM_BANKS), bank_we (output, 1), bank_row (output, SCPAD_ADDR_WIDTH), bank_wdata (output, scpad_data) and bank_rdata (input, scpad_data): the SRAM bank port.

Function
REQ-015 SHALL implement FSM states IDLE, ISSUE, WAIT and RESP.
REQ-016 SHALL, in IDLE with any request high, grant exactly one requester in that cycle with fixed priority BE > VC > SA, pulse its sram_reserved_* for one cycle, latch slot, row and owner (plus xbar_out for BE), then go to ISSUE.
REQ-017 SHALL ignore requests outside IDLE; a requester holds its req until reserved, and a req dropped before grant is lost without error.
REQ-018 SHALL, in ISSUE, drive bank_en=latched slot, bank_row=latched row and bank_we=(owner==BE) for exactly one cycle; for BE, bank_wdata=latched data, then go to IDLE.
REQ-019 SHALL, for reads, go from ISSUE to WAIT, count SRAM_LAT cycles, capture bank_rdata on the final count, then go to RESP.
REQ-020 SHALL, in RESP, for one cycle drive resp_valid with the single owner bit set, resp_rdata=captured data, and xbar_in_vc or xbar_in_sa (owner only, other zero)=captured data, then go to IDLE.
REQ-021 SHALL meet the latency: grant at cycle T -> bank_en at T+1 -> resp_valid at T+2+SRAM_LAT; write grant T -> IDLE at T+2.
REQ-022 SHALL keep bank_en, bank_we, resp_valid, sram_reserved_* and xbar_in_* at 0 outside the states named above.
REQ-023 SHALL drive resp_ready=1 only in IDLE.
REQ-024 SHALL allow back-to-back operation with a minimum request spacing of one IDLE cycle between operations.

Reset
REQ-025 SHALL, when rst=1 at a clock edge, enter IDLE, clear all latches and counters, and drive all outputs 0 except resp_ready=1 after the edge.
REQ-026 SHALL, on reset mid-operation, abort with no bank access, resp or grant emitted afterward.

Configuration
REQ-027 SHALL, with SCPAD_SA_AGING_EN defined, count the cycles in which sram_req_sa=1 in IDLE without an SA grant; at count>=AGE_LIMIT, grant SA over VC (BE still wins); clear the count on SA grant or when sram_req_sa=0.
REQ-028 SHALL, without SCPAD_SA_AGING_EN, use strict BE>VC>SA priority with no counter logic and ignore AGE_LIMIT.

Structure
REQ-029 SHALL place arb_owner_e (OWN_NONE, OWN_BE, OWN_VC, OWN_SA) and arb_state_e in spad_types_pkg, which also holds scpad_data, slot_mask, NUM_BANKS and SCPAD_ADDR_WIDTH.
REQ-030 SHALL put the priority and aging decision in sub-module scpad_prio_arbiter (combinational grant, plus the aging counter when enabled).

Verification
REQ-031 SHALL cover: reset, then BE write with slot=4'b0011, row=5, data=0xA5.. -> reserved_be at T, bank_en=0011, bank_we=1, row=5 at T+1, IDLE at T+2.
REQ-032 SHALL cover: VC read with SRAM_LAT=2 and bank_rdata=0x1234 -> reserved_vc at T, resp_valid=2'b10 with rdata=0x1234 at T+4, xbar_in_sa=0.
REQ-033 SHALL cover: BE, VC and SA requested in the same cycle -> grant order BE, VC, SA across three operations.
REQ-034 SHALL cover: rst asserted during WAIT -> no resp_valid follows, resp_ready=1 the next cycle.
REQ-035 SHALL cover, with aging on and AGE_LIMIT=3: VC and SA held continuously -> SA granted on the 4th arbitration.
REQ-036 SHALL cover, with aging off: the same stimulus as REQ-035 -> SA never granted while VC is held.
